rs_issue_select: RTL and testbench

- Issue-side partner of the reservation station.
- Each cycle it consumes the RS `ready` vector and entry packets, and picks up to ISSUE_WIDTH entries under functional-unit constraints.
- It returns a one-hot-per-grant `free` mask to the RS, so the RS vacates those entries at the next edge.
- It registers the selected packets into the issue/execute pipeline register.
- It also tracks the non-pipelined multiplier's busy window, so no MULT is granted while the unit is occupied.

---
 rtl/sys_defs.sv | 31 +++
 rtl/rr_pick_n.sv | 51 +++++
 rtl/rs_issue_select.sv | 111 +++++++++++
 tb/tb_rs_issue_select.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared processor definitions: RS sizing, functional-unit codes and the packet
// handed from the reservation station to the issue stage.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV

`define RS_SIZE 16

package sys_defs;

    localparam int MULT_LAT_DEFAULT = 4;

    typedef enum logic [2:0] {
        FUNC_ALU    = 3'd0,
        FUNC_MULT   = 3'd1,
        FUNC_LOAD   = 3'd2,
        FUNC_STORE  = 3'd3,
        FUNC_BRANCH = 3'd4
    } FUNC_UNIT;

    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        inst;
        FUNC_UNIT           func_unit;
        logic [5:0]         dest_tag;
        logic signed [31:0] opa_value;
        logic signed [31:0] opb_value;
    } RS_IS_PACKET;

endpackage

`endif

// File: rtl/rr_pick_n.sv
// Circular priority picker: walks the request vector starting at `start` and
// hands out up to W one-hot grants, admitting at most one multiplier op.
module rr_pick_n #(
    parameter int N = 16,
    parameter int W = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         req,
    input  logic [PW-1:0]        start,
    input  logic [N-1:0]         mult_mask,
    output logic [W-1:0][N-1:0]  gnt,
    output logic [W-1:0][PW-1:0] gnt_idx,
    output logic [W-1:0]         gnt_vld
);

    localparam int          PW1 = PW + 1;
    localparam logic [PW:0] N_L = PW1'(N);

    always_comb begin
        logic [PW:0]   pos;
        logic [PW-1:0] idx;
        int            cnt;
        logic          mult_taken;
        gnt        = '0;
        gnt_idx    = '0;
        gnt_vld    = '0;
        pos        = '0;
        idx        = '0;
        cnt        = 0;
        mult_taken = 1'b0;
        for (int s = 0; s < N; s++) begin
            pos = {1'b0, start} + PW1'(s);
            if (pos >= N_L) pos = pos - N_L;
            idx = pos[PW-1:0];
            // A second MULT is skipped rather than ending the scan, so younger
            // non-MULT entries behind it can still take the remaining slots.
            if (req[idx] && !(mult_mask[idx] && mult_taken) && cnt < W) begin
                for (int k = 0; k < W; k++) begin
                    if (cnt == k) begin
                        gnt[k][idx] = 1'b1;
                        gnt_idx[k]  = idx;
                        gnt_vld[k]  = 1'b1;
                    end
                end
                if (mult_mask[idx]) mult_taken = 1'b1;
                cnt = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/rs_issue_select.sv
// Issue select: picks ready RS entries round-robin under FU constraints, frees
// them in the RS and registers them into the issue/execute pipeline register.
module rs_issue_select
    import sys_defs::*;
#(
    parameter int RS_SIZE     = `RS_SIZE,
    parameter int ISSUE_WIDTH = 2,
    parameter int MULT_LAT    = MULT_LAT_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   squash_signal_in,
    input  logic [RS_SIZE-1:0]     ready,
    input  RS_IS_PACKET            rs_in [RS_SIZE],
    input  logic                   ex_stall,
    output logic [RS_SIZE-1:0]     free,
    output RS_IS_PACKET            is_ex_out [ISSUE_WIDTH],
    output logic [ISSUE_WIDTH-1:0] is_ex_valid,
    output logic                   mult_busy
);

    localparam int PW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    logic [PW-1:0]                    rr_ptr;
    logic [CW-1:0]                    mult_cnt;
    logic [RS_SIZE-1:0]               mult_mask;
    logic [RS_SIZE-1:0]               req_p0;
    logic [ISSUE_WIDTH-1:0][RS_SIZE-1:0] gnt_p0;
    logic [ISSUE_WIDTH-1:0][PW-1:0]   gnt_idx_p0;
    logic [ISSUE_WIDTH-1:0]           gnt_vld_p0;
    logic                             grant_en;
    logic                             mult_grant;
    logic [PW-1:0]                    nxt_ptr;

    assign mult_busy = (mult_cnt != '0);
    // Reset is folded in so free reads 0 while reset is held, not only after an edge.
    assign grant_en  = reset && !ex_stall && !squash_signal_in;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            mult_mask[i] = (rs_in[i].func_unit == FUNC_MULT);
        end
    end

    assign req_p0 = ready & ~(mult_mask & {RS_SIZE{mult_busy}}) & {RS_SIZE{grant_en}};

    rr_pick_n #(
        .N (RS_SIZE),
        .W (ISSUE_WIDTH)
    ) u_pick (
        .req       (req_p0),
        .start     (rr_ptr),
        .mult_mask (mult_mask),
        .gnt       (gnt_p0),
        .gnt_idx   (gnt_idx_p0),
        .gnt_vld   (gnt_vld_p0)
    );

    always_comb begin
        free = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            free = free | gnt_p0[k];
        end
    end

    assign mult_grant = |(free & mult_mask);

    // Slots fill in scan order, so the last valid slot is the furthest grant.
    always_comb begin
        nxt_ptr = rr_ptr;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (gnt_vld_p0[k]) begin
                nxt_ptr = (gnt_idx_p0[k] == PW'(RS_SIZE - 1)) ? '0 : gnt_idx_p0[k] + PW'(1);
            end
        end
    end

    // Stage boundary: select -> issue/execute register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                is_ex_out[k] <= '0;
            end
            is_ex_valid <= '0;
            rr_ptr      <= '0;
            mult_cnt    <= '0;
        end else begin
            if (squash_signal_in) begin
                is_ex_valid <= '0;
                mult_cnt    <= '0;
            end else begin
                if (!ex_stall) begin
                    for (int k = 0; k < ISSUE_WIDTH; k++) begin
                        is_ex_out[k] <= rs_in[gnt_idx_p0[k]];
                    end
                    is_ex_valid <= gnt_vld_p0;
                end
                if (mult_grant) begin
                    mult_cnt <= CW'(MULT_LAT - 1);
                end else if (mult_cnt != '0) begin
                    mult_cnt <= mult_cnt - CW'(1);
                end
            end
            if (|gnt_vld_p0) begin
                rr_ptr <= nxt_ptr;
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_select.sv
// Bench for rs_issue_select: cycle table with a scoreboard of registered results,
// followed by a hand-written asynchronous reset sequence.
module tb_rs_issue_select;
    import sys_defs::*;

    localparam int N  = 16;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              squash_signal_in;
    logic              ex_stall;
    logic [N-1:0]      ready;
    logic [N-1:0]      free;
    RS_IS_PACKET       rs_in [N];
    RS_IS_PACKET       is_ex_out [IW];
    logic [IW-1:0]     is_ex_valid;
    logic              mult_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] ready;
        logic [15:0] mult;
        logic        stall;
        logic        squash;
        logic [15:0] free;
        logic        bnow;
        logic [1:0]  vld;
        int          e0;
        int          e1;
        logic        bafter;
    } vec_t;

    typedef struct {
        logic [1:0] vld;
        int         e0;
        int         e1;
        logic       busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    rs_issue_select #(
        .RS_SIZE     (N),
        .ISSUE_WIDTH (IW),
        .MULT_LAT    (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .squash_signal_in (squash_signal_in),
        .ready            (ready),
        .rs_in            (rs_in),
        .ex_stall         (ex_stall),
        .free             (free),
        .is_ex_out        (is_ex_out),
        .is_ex_valid      (is_ex_valid),
        .mult_busy        (mult_busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pc_of(input int e);
        return 32'h1000 + 32'(e * 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] rdy, input logic [15:0] mlt,
                         input logic st, input logic sq);
        ready            = rdy;
        ex_stall         = st;
        squash_signal_in = sq;
        for (int i = 0; i < N; i++) begin
            rs_in[i].func_unit = mlt[i] ? FUNC_MULT : FUNC_ALU;
        end
    endtask

    task automatic add(input logic [15:0] rdy, input logic [15:0] mlt,
                       input logic st, input logic sq, input logic [15:0] fr,
                       input logic bn, input logic [1:0] v, input int e0,
                       input int e1, input logic ba);
        vec_t r;
        r.ready = rdy; r.mult = mlt; r.stall = st; r.squash = sq; r.free = fr;
        r.bnow = bn; r.vld = v; r.e0 = e0; r.e1 = e1; r.bafter = ba;
        tbl.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            rs_in[i]          = '0;
            rs_in[i].pc       = pc_of(i);
            rs_in[i].inst     = 32'h13 + 32'(i);
            rs_in[i].dest_tag = 6'(i);
        end
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset_valid", 32'(is_ex_valid), 32'h0);
        chk("reset_busy", 32'(mult_busy), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        //  ready     mult      st    sq    free     bnow  vld    e0  e1  bafter
        add(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b00, 0,  0,  1'b0);
        add(16'h0006, 16'h0000, 1'b0, 1'b0, 16'h0006, 1'b0, 2'b11, 1,  2,  1'b0);
        add(16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 2'b01, 0,  0,  1'b0);
        add(16'h2000, 16'h0000, 1'b0, 1'b0, 16'h2000, 1'b0, 2'b01, 13, 0,  1'b0);
        add(16'h8003, 16'h0000, 1'b0, 1'b0, 16'h8001, 1'b0, 2'b11, 15, 0,  1'b0);
        add(16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0003, 1'b0, 2'b11, 1,  0,  1'b0);
        add(16'h8000, 16'h0000, 1'b0, 1'b0, 16'h8000, 1'b0, 2'b01, 15, 0,  1'b0);
        add(16'h0007, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 2'b11, 0,  2,  1'b1);
        add(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0000, 1'b1, 2'b00, 0,  0,  1'b1);
        add(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0000, 1'b1, 2'b00, 0,  0,  1'b1);
        add(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0000, 1'b1, 2'b00, 0,  0,  1'b0);
        add(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0002, 1'b0, 2'b01, 1,  0,  1'b1);
        add(16'h0032, 16'h0002, 1'b0, 1'b0, 16'h0030, 1'b1, 2'b11, 4,  5,  1'b1);
        add(16'h00C0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 2'b00, 0,  0,  1'b0);
        add(16'h0008, 16'h0000, 1'b0, 1'b0, 16'h0008, 1'b0, 2'b01, 3,  0,  1'b0);
        add(16'h00F0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 2'b01, 3,  0,  1'b0);
        add(16'h00F0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 2'b01, 3,  0,  1'b0);
        add(16'h00F0, 16'h0000, 1'b0, 1'b0, 16'h0030, 1'b0, 2'b11, 4,  5,  1'b0);
        add(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 2'b01, 0,  0,  1'b1);
        add(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01, 0,  0,  1'b1);
        add(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01, 0,  0,  1'b1);
        add(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01, 0,  0,  1'b0);
        add(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b00, 0,  0,  1'b0);

        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clock);
            drive(tbl[r].ready, tbl[r].mult, tbl[r].stall, tbl[r].squash);
            #1;
            chk($sformatf("row%0d_free", r), 32'(free), 32'(tbl[r].free));
            chk($sformatf("row%0d_busy_now", r), 32'(mult_busy), 32'(tbl[r].bnow));
            e.vld = tbl[r].vld; e.e0 = tbl[r].e0; e.e1 = tbl[r].e1; e.busy = tbl[r].bafter;
            sb.push_back(e);
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL row%0d_scoreboard: got empty queue expected entry", r);
            end else begin
                e = sb.pop_front();
                chk($sformatf("row%0d_valid", r), 32'(is_ex_valid), 32'(e.vld));
                if (e.vld[0]) chk($sformatf("row%0d_slot0", r), is_ex_out[0].pc, pc_of(e.e0));
                if (e.vld[1]) chk($sformatf("row%0d_slot1", r), is_ex_out[1].pc, pc_of(e.e1));
                chk($sformatf("row%0d_busy_after", r), 32'(mult_busy), 32'(e.busy));
            end
        end

        // Asynchronous reset mid-run with valid outputs and a busy multiplier
        @(negedge clock);
        drive(16'h0003, 16'h0001, 1'b0, 1'b0);
        #1;
        chk("pre_reset_free", 32'(free), 32'h0003);
        @(posedge clock);
        #1;
        chk("pre_reset_valid", 32'(is_ex_valid), 32'h3);
        chk("pre_reset_slot0", is_ex_out[0].pc, pc_of(1));
        chk("pre_reset_busy", 32'(mult_busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_valid", 32'(is_ex_valid), 32'h0);
        chk("async_reset_free", 32'(free), 32'h0);
        chk("async_reset_busy", 32'(mult_busy), 32'h0);
        chk("async_reset_slot0", is_ex_out[0].pc, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        drive(16'h0003, 16'h0000, 1'b0, 1'b0);
        #1;
        chk("post_reset_free", 32'(free), 32'h0003);
        @(posedge clock);
        #1;
        chk("post_reset_valid", 32'(is_ex_valid), 32'h3);
        chk("post_reset_slot0", is_ex_out[0].pc, pc_of(0));
        chk("post_reset_slot1", is_ex_out[1].pc, pc_of(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
